ocp_arb2: RTL and testbench



---
 rtl/ocp_arb2_pkg.sv | 13 +
 rtl/ocp_arb2_rr_arb2.sv | 13 +
 rtl/ocp_arb2.sv | 110 +++++++++++
 tb/tb_ocp_arb2.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocp_arb2_pkg.sv
// ocp_arb2_pkg: shared OCP widths and command/response encodings for the two-master arbiter
package ocp_arb2_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BEN_WIDTH  = 4;
    localparam int CNT_WIDTH  = 16;
    localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_CMD_READ  = 3'd2;
    localparam logic [1:0] OCP_RESP_NULL = 2'd0;
    localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
    localparam logic [1:0] OCP_RESP_ERR  = 2'd3;
endpackage

// File: rtl/ocp_arb2_rr_arb2.sv
// rr_arb2: two-way round-robin grant decision, purely combinational
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic       o_gnt,
    output logic       o_valid
);
    // on a tie the master that did not win last time goes next
    always_comb begin
        o_valid = |i_req;
        o_gnt   = (&i_req) ? ~i_last_gnt : i_req[1];
    end
endmodule

// File: rtl/ocp_arb2.sv
// ocp_arb2: shares one OCP slave between two masters, one outstanding transaction, with response timeout
module ocp_arb2
    import ocp_arb2_pkg::*;
#(
    parameter int RESP_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_M0Addr,
    input  logic [2:0]            i_M0Cmd,
    input  logic [DATA_WIDTH-1:0] i_M0Data,
    input  logic [BEN_WIDTH-1:0]  i_M0ByteEn,
    input  logic [ADDR_WIDTH-1:0] i_M1Addr,
    input  logic [2:0]            i_M1Cmd,
    input  logic [DATA_WIDTH-1:0] i_M1Data,
    input  logic [BEN_WIDTH-1:0]  i_M1ByteEn,
    output logic                  o_S0CmdAccept,
    output logic [DATA_WIDTH-1:0] o_S0Data,
    output logic [1:0]            o_S0Resp,
    output logic                  o_S1CmdAccept,
    output logic [DATA_WIDTH-1:0] o_S1Data,
    output logic [1:0]            o_S1Resp,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [BEN_WIDTH-1:0]  o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

    localparam logic [CNT_WIDTH-1:0] TMO    = CNT_WIDTH'(RESP_TIMEOUT);
    localparam bit                   TMO_EN = RESP_TIMEOUT != 0;

    state_t                r_state;
    logic                  r_gnt;
    logic                  r_last_gnt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [1:0]            w_req;
    logic                  w_win;
    logic                  w_valid;
    logic                  w_issue;
    logic                  w_resp;
    logic                  w_tmo;
    logic                  w_done;
    logic                  w_acc;
    logic [DATA_WIDTH-1:0] w_data;
    logic [1:0]            w_rsp;

    assign w_req = {i_M1Cmd != OCP_CMD_IDLE, i_M0Cmd != OCP_CMD_IDLE};

    rr_arb2 u_rr (
        .i_req      (w_req),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_win),
        .o_valid    (w_valid)
    );

    // completion detection and routing of command/response to the current owner
    always_comb begin
        w_issue       = r_state == ST_ISSUE;
        w_resp        = (i_SResp != OCP_RESP_NULL) && (r_state == ST_WAIT || (w_issue && i_SCmdAccept));
        w_tmo         = TMO_EN && r_state != ST_IDLE && r_cnt == TMO && !w_resp;
        w_done        = w_resp || w_tmo;
        w_acc         = w_issue && (i_SCmdAccept || w_tmo);
        w_data        = w_resp ? i_SData : '0;
        w_rsp         = w_resp ? i_SResp : (w_tmo ? OCP_RESP_ERR : OCP_RESP_NULL);
        o_S0CmdAccept = w_acc && !r_gnt;
        o_S1CmdAccept = w_acc && r_gnt;
        o_S0Data      = r_gnt ? '0 : w_data;
        o_S1Data      = r_gnt ? w_data : '0;
        o_S0Resp      = r_gnt ? OCP_RESP_NULL : w_rsp;
        o_S1Resp      = r_gnt ? w_rsp : OCP_RESP_NULL;
        o_MCmd        = w_issue ? (r_gnt ? i_M1Cmd : i_M0Cmd) : OCP_CMD_IDLE;
        o_MAddr       = w_issue ? (r_gnt ? i_M1Addr : i_M0Addr) : '0;
        o_MData       = w_issue ? (r_gnt ? i_M1Data : i_M0Data) : '0;
        o_MByteEn     = w_issue ? (r_gnt ? i_M1ByteEn : i_M0ByteEn) : '0;
    end

    // grant, round-robin history, transaction phase and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state    <= ST_ISSUE;
                        r_gnt      <= w_win;
                        r_last_gnt <= w_win;
                        r_cnt      <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_done ? ST_IDLE : (i_SCmdAccept ? ST_WAIT : ST_ISSUE);
                end
                ST_WAIT: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_done ? ST_IDLE : ST_WAIT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ocp_arb2.sv
// tb_ocp_arb2: directed and randomized checks of two arbiter instances (timeout 8 and timeout disabled)
module tb_ocp_arb2;
    import ocp_arb2_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  m_cmd  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_ben  [2];
    logic        s_cacc;
    logic [31:0] s_data;
    logic [1:0]  s_resp;

    logic        o_acc   [2][2];
    logic [31:0] o_dat   [2][2];
    logic [1:0]  o_rsp   [2][2];
    logic [31:0] o_maddr [2];
    logic [2:0]  o_mcmd  [2];
    logic [31:0] o_mdata [2];
    logic [3:0]  o_mben  [2];

    ocp_arb2 #(.RESP_TIMEOUT(8)) u_t8 (
        .clk(clk), .rst(rst),
        .i_M0Addr(m_addr[0]), .i_M0Cmd(m_cmd[0]), .i_M0Data(m_data[0]), .i_M0ByteEn(m_ben[0]),
        .i_M1Addr(m_addr[1]), .i_M1Cmd(m_cmd[1]), .i_M1Data(m_data[1]), .i_M1ByteEn(m_ben[1]),
        .o_S0CmdAccept(o_acc[0][0]), .o_S0Data(o_dat[0][0]), .o_S0Resp(o_rsp[0][0]),
        .o_S1CmdAccept(o_acc[0][1]), .o_S1Data(o_dat[0][1]), .o_S1Resp(o_rsp[0][1]),
        .o_MAddr(o_maddr[0]), .o_MCmd(o_mcmd[0]), .o_MData(o_mdata[0]), .o_MByteEn(o_mben[0]),
        .i_SCmdAccept(s_cacc), .i_SData(s_data), .i_SResp(s_resp)
    );

    ocp_arb2 #(.RESP_TIMEOUT(0)) u_t0 (
        .clk(clk), .rst(rst),
        .i_M0Addr(m_addr[0]), .i_M0Cmd(m_cmd[0]), .i_M0Data(m_data[0]), .i_M0ByteEn(m_ben[0]),
        .i_M1Addr(m_addr[1]), .i_M1Cmd(m_cmd[1]), .i_M1Data(m_data[1]), .i_M1ByteEn(m_ben[1]),
        .o_S0CmdAccept(o_acc[1][0]), .o_S0Data(o_dat[1][0]), .o_S0Resp(o_rsp[1][0]),
        .o_S1CmdAccept(o_acc[1][1]), .o_S1Data(o_dat[1][1]), .o_S1Resp(o_rsp[1][1]),
        .o_MAddr(o_maddr[1]), .o_MCmd(o_mcmd[1]), .o_MData(o_mdata[1]), .o_MByteEn(o_mben[1]),
        .i_SCmdAccept(s_cacc), .i_SData(s_data), .i_SResp(s_resp)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: per instance, a transaction is either absent, waiting for accept, or waiting for response
    int  tmo_cfg [2] = '{8, 0};
    bit  mb_busy [2];
    bit  mb_acc  [2];
    bit  mb_own  [2];
    bit  mb_last [2];
    int  mb_age  [2];
    bit  e_acc   [2][2];
    bit  run = 1'b0;
    bit  b_r0, b_r1, b_iss, b_rin, b_tmo, b_xa, b_own;
    logic [1:0]  x_rsp;
    logic [31:0] x_dat;
    int  x_o;

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                b_iss = mb_busy[k] && !mb_acc[k];
                b_rin = mb_busy[k] && s_resp != OCP_RESP_NULL && (mb_acc[k] || s_cacc);
                b_tmo = mb_busy[k] && tmo_cfg[k] != 0 && mb_age[k] == tmo_cfg[k] && !b_rin;
                b_xa  = b_iss && (s_cacc || b_tmo);
                x_rsp = b_rin ? s_resp : (b_tmo ? OCP_RESP_ERR : OCP_RESP_NULL);
                x_dat = b_rin ? s_data : 32'd0;
                x_o   = int'(mb_own[k]);
                for (int m = 0; m < 2; m++) begin
                    b_own = mb_busy[k] && x_o == m;
                    chk($sformatf("i%0d_acc%0d", k, m), o_acc[k][m], b_own ? b_xa : 1'b0);
                    chk($sformatf("i%0d_resp%0d", k, m), o_rsp[k][m], b_own ? x_rsp : OCP_RESP_NULL);
                    chk($sformatf("i%0d_data%0d", k, m), o_dat[k][m], b_own ? x_dat : 32'd0);
                    e_acc[k][m] = b_own && b_xa;
                end
                chk($sformatf("i%0d_mcmd", k), o_mcmd[k], b_iss ? m_cmd[x_o] : OCP_CMD_IDLE);
                chk($sformatf("i%0d_maddr", k), o_maddr[k], b_iss ? m_addr[x_o] : 32'd0);
                chk($sformatf("i%0d_mdata", k), o_mdata[k], b_iss ? m_data[x_o] : 32'd0);
                chk($sformatf("i%0d_mben", k), o_mben[k], b_iss ? m_ben[x_o] : 4'd0);
                b_r0 = m_cmd[0] != OCP_CMD_IDLE;
                b_r1 = m_cmd[1] != OCP_CMD_IDLE;
                if (rst) begin
                    mb_busy[k] = 1'b0;
                    mb_acc[k]  = 1'b0;
                    mb_last[k] = 1'b1;
                    mb_age[k]  = 0;
                end else if (!mb_busy[k]) begin
                    if (b_r0 || b_r1) begin
                        mb_own[k]  = (b_r0 && b_r1) ? !mb_last[k] : b_r1;
                        mb_last[k] = mb_own[k];
                        mb_busy[k] = 1'b1;
                        mb_acc[k]  = 1'b0;
                        mb_age[k]  = 0;
                    end
                end else begin
                    if (b_rin || b_tmo) mb_busy[k] = 1'b0;
                    else if (b_iss && s_cacc) mb_acc[k] = 1'b1;
                    mb_age[k]++;
                end
            end
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        for (int m = 0; m < 2; m++) begin
            m_cmd[m]  = OCP_CMD_IDLE;
            m_addr[m] = 32'd0;
            m_data[m] = 32'd0;
            m_ben[m]  = 4'd0;
        end
        s_cacc = 1'b0;
        s_resp = OCP_RESP_NULL;
        s_data = 32'd0;
    endtask

    task automatic do_rst();
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        nx();
        rst = 1'b0;
    endtask

    task automatic rand_cycle();
        for (int m = 0; m < 2; m++) begin
            if (m_cmd[m] == OCP_CMD_IDLE || e_acc[0][m]) begin
                m_cmd[m]  = ($urandom % 3 == 0) ? OCP_CMD_IDLE : (($urandom % 2 == 0) ? OCP_CMD_WRITE : OCP_CMD_READ);
                m_addr[m] = $urandom;
                m_data[m] = $urandom;
                m_ben[m]  = 4'($urandom);
            end
        end
        rst    = ($urandom % 250) == 0;
        s_data = $urandom;
        if (mb_busy[0] && !mb_acc[0]) begin
            s_cacc = ($urandom % 4) == 0;
            s_resp = (s_cacc && $urandom % 2 == 0) ? 2'($urandom_range(1, 3)) : OCP_RESP_NULL;
        end else if (mb_busy[0]) begin
            s_cacc = ($urandom % 2) == 0;
            s_resp = ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : OCP_RESP_NULL;
        end else begin
            s_cacc = ($urandom % 2) == 0;
            s_resp = ($urandom % 10 == 0) ? OCP_RESP_DVA : OCP_RESP_NULL;
        end
    endtask

    int bad;

    initial begin
        idle_in();
        for (int k = 0; k < 2; k++) begin
            mb_busy[k] = 1'b0;
            mb_acc[k]  = 1'b0;
            mb_own[k]  = 1'b0;
            mb_last[k] = 1'b1;
            mb_age[k]  = 0;
            e_acc[k]   = '{1'b0, 1'b0};
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        @(negedge clk);
        chk("rst_mcmd", o_mcmd[0], OCP_CMD_IDLE);
        chk("rst_s0resp", o_rsp[0][0], OCP_RESP_NULL);
        nx();
        rst = 1'b0;

        // lone M0 read, slave answers in the issue cycle
        m_cmd[0]  = OCP_CMD_READ;
        m_addr[0] = 32'h004;
        @(negedge clk);
        nx();
        s_cacc = 1'b1;
        s_resp = OCP_RESP_DVA;
        s_data = 32'h4000_0000;
        @(negedge clk);
        chk("d1_acc", o_acc[0][0], 1);
        chk("d1_resp", o_rsp[0][0], OCP_RESP_DVA);
        chk("d1_data", o_dat[0][0], 32'h4000_0000);
        chk("d1_m1resp", o_rsp[0][1], OCP_RESP_NULL);
        chk("d1_maddr", o_maddr[0], 32'h004);
        nx();
        idle_in();
        @(negedge clk);
        nx();

        // both masters writing continuously: grants alternate, two cycles each
        do_rst();
        m_cmd     = '{OCP_CMD_WRITE, OCP_CMD_WRITE};
        m_data[0] = 32'hA0;
        m_data[1] = 32'hA1;
        s_cacc    = 1'b1;
        s_resp    = OCP_RESP_DVA;
        s_data    = 32'h5;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                chk("d2_mdata", o_mdata[0], (c % 4 == 1) ? 32'hA0 : 32'hA1);
                chk("d2_acc", o_acc[0][(c % 4 == 1) ? 0 : 1], 1);
            end else begin
                chk("d2_idle", o_mcmd[0], OCP_CMD_IDLE);
            end
            nx();
        end

        // accept now, respond three cycles later, only to M1
        do_rst();
        m_cmd[1]  = OCP_CMD_READ;
        m_addr[1] = 32'h8;
        @(negedge clk);
        nx();
        s_cacc = 1'b1;
        @(negedge clk);
        chk("d3_acc", o_acc[0][1], 1);
        nx();
        m_cmd[1] = OCP_CMD_IDLE;
        s_cacc   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("d3_wait_cmd", o_mcmd[0], OCP_CMD_IDLE);
            chk("d3_wait_resp", o_rsp[0][1], OCP_RESP_NULL);
            nx();
        end
        s_resp = OCP_RESP_DVA;
        s_data = 32'd77;
        @(negedge clk);
        chk("d3_m1resp", o_rsp[0][1], OCP_RESP_DVA);
        chk("d3_m1data", o_dat[0][1], 32'd77);
        chk("d3_m0resp", o_rsp[0][0], OCP_RESP_NULL);
        nx();

        // slave never accepts: error completion 8 cycles after issue entry
        do_rst();
        m_cmd[0] = OCP_CMD_READ;
        @(negedge clk);
        nx();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                chk("d4_noacc", o_acc[0][0], 0);
            end else begin
                chk("d4_acc", o_acc[0][0], 1);
                chk("d4_err", o_rsp[0][0], OCP_RESP_ERR);
                chk("d4_data", o_dat[0][0], 32'd0);
            end
            nx();
        end
        m_cmd[0] = OCP_CMD_IDLE;
        s_resp   = OCP_RESP_DVA;
        s_data   = 32'd123;
        @(negedge clk);
        chk("d4_late", o_rsp[0][0], OCP_RESP_NULL);
        nx();

        // reset during wait abandons the transaction; next tie goes to M0
        do_rst();
        m_cmd[0] = OCP_CMD_READ;
        @(negedge clk);
        nx();
        s_cacc = 1'b1;
        @(negedge clk);
        nx();
        m_cmd[0] = OCP_CMD_IDLE;
        s_cacc   = 1'b0;
        @(negedge clk);
        nx();
        rst = 1'b1;
        @(negedge clk);
        nx();
        rst       = 1'b0;
        s_resp    = OCP_RESP_DVA;
        s_data    = 32'd9;
        m_cmd     = '{OCP_CMD_WRITE, OCP_CMD_WRITE};
        m_data[0] = 32'hA0;
        m_data[1] = 32'hA1;
        @(negedge clk);
        chk("d5_rst_resp", o_rsp[0][0], OCP_RESP_NULL);
        chk("d5_rst_mcmd", o_mcmd[0], OCP_CMD_IDLE);
        nx();
        s_resp = OCP_RESP_NULL;
        @(negedge clk);
        chk("d5_tie", o_mdata[0], 32'hA0);
        nx();

        // timeout disabled: silent slave leaves the transaction waiting
        do_rst();
        m_cmd[0] = OCP_CMD_READ;
        @(negedge clk);
        nx();
        s_cacc = 1'b1;
        @(negedge clk);
        nx();
        m_cmd[0] = OCP_CMD_IDLE;
        s_cacc   = 1'b0;
        bad      = 0;
        repeat (2000) begin
            @(negedge clk);
            if (o_rsp[1][0] != OCP_RESP_NULL || o_mcmd[1] != OCP_CMD_IDLE) bad++;
            nx();
        end
        chk("d6_no_tmo", bad, 0);
        s_resp = OCP_RESP_DVA;
        s_data = 32'd55;
        @(negedge clk);
        chk("d6_resp", o_rsp[1][0], OCP_RESP_DVA);
        nx();

        // randomized traffic against the reference
        do_rst();
        repeat (3000) begin
            rand_cycle();
            @(negedge clk);
            nx();
        end
        rst = 1'b0;
        @(negedge clk);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
